// File: rtl/lib_arbiter_pkg.sv
// lib_arbiter_pkg: shared types and defaults for the row arbiter hierarchy
package lib_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ARB, WAIT_GNT, SEND} rowreq_state_t;
  localparam int ROWREQ_CNT_W_DEF = 3;
endpackage

// File: rtl/row_pending_cnt.sv
// row_pending_cnt: saturating inc/dec pending counter with overflow pulse
module row_pending_cnt import lib_arbiter_pkg::*; #(
  parameter int W = ROWREQ_CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf
);
  localparam logic [W-1:0] MAX = '1;
  assign ovf = inc & ~dec & (cnt == MAX);
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt <= '0;
    else if (inc && !dec && cnt != MAX) cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/row_event_requester.sv
// row_event_requester: per-row event accumulation, arbiter sequencing, address-event output.
// Define ROWREQ_GNT_CHECK_EN to add grant-protocol checking and the sticky err_o flag.
module row_event_requester import lib_arbiter_pkg::*; #(
  parameter int Lvl_ROWS    = 4,
  parameter int Lvl_ROW_ADD = 2,
  parameter int EVT_CNT_W   = ROWREQ_CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [Lvl_ROWS-1:0]    event_i,
  output logic [Lvl_ROWS-1:0]    req_o,
  input  logic [Lvl_ROWS-1:0]    gnt_i,
  output logic                   arb_en_o,
  output logic                   refresh_o,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [Lvl_ROW_ADD-1:0] evt_row_o,
  output logic                   overflow_o
`ifdef ROWREQ_GNT_CHECK_EN
  ,
  output logic                   err_o
`endif
);
  logic [EVT_CNT_W-1:0]   cnt [Lvl_ROWS];
  logic [Lvl_ROWS-1:0]    ovf, dec;
  logic [Lvl_ROW_ADD-1:0] gnt_idx;
  logic                   gnt_ok, refresh_done;
  rowreq_state_t          state;

  for (genvar i = 0; i < Lvl_ROWS; i++) begin : g_row
    row_pending_cnt #(.W(EVT_CNT_W)) u_cnt (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .inc      (event_i[i]),
      .dec      (dec[i]),
      .cnt      (cnt[i]),
      .ovf      (ovf[i])
    );
    assign req_o[i] = |cnt[i];
    assign dec[i]   = evt_valid_o & evt_ready_i & (evt_row_o == Lvl_ROW_ADD'(i));
  end

  // lowest set bit wins, so a malformed grant still maps to a defined row
  always_comb begin
    gnt_idx = '0;
    for (int r = Lvl_ROWS - 1; r >= 0; r--) if (gnt_i[r]) gnt_idx = Lvl_ROW_ADD'(r);
  end

`ifdef ROWREQ_GNT_CHECK_EN
  assign gnt_ok = $onehot(gnt_i) && req_o[gnt_idx];
`else
  assign gnt_ok = |gnt_i;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      refresh_done <= 1'b0;
      arb_en_o     <= 1'b0;
      refresh_o    <= 1'b0;
      evt_valid_o  <= 1'b0;
      evt_row_o    <= '0;
    end else begin
      arb_en_o  <= 1'b0;
      refresh_o <= 1'b0;
      case (state)
        IDLE:
          if (|req_o) begin
            state        <= ARB;
            arb_en_o     <= 1'b1;
            refresh_done <= 1'b0;
          end else if (!refresh_done) begin
            refresh_o    <= 1'b1;
            refresh_done <= 1'b1;
          end
        ARB: state <= WAIT_GNT;
        WAIT_GNT: begin
          evt_row_o   <= gnt_idx;
          evt_valid_o <= gnt_ok;
          state       <= gnt_ok ? SEND : IDLE;
        end
        SEND:
          if (evt_ready_i) begin
            evt_valid_o <= 1'b0;
            state       <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overflow_o <= 1'b0;
`ifdef ROWREQ_GNT_CHECK_EN
      err_o      <= 1'b0;
`endif
    end else begin
      overflow_o <= overflow_o | (|ovf);
`ifdef ROWREQ_GNT_CHECK_EN
      err_o      <= err_o | (state == WAIT_GNT && !gnt_ok);
`endif
    end
  end
endmodule

// File: tb/tb_row_event_requester.sv
// tb_row_event_requester: directed and random checks against a pending-count scoreboard and round-robin arbiter model
module tb_row_event_requester;
  logic       clk = 1'b0;
  logic       reset_n_i = 1'b1;
  logic [3:0] event_i = '0;
  logic [3:0] req_o;
  logic [3:0] gnt_i;
  logic       arb_en_o, refresh_o, evt_valid_o, overflow_o;
  logic       evt_ready_i = 1'b1;
  logic [1:0] evt_row_o;
`ifdef ROWREQ_GNT_CHECK_EN
  logic       err_o;
`endif

  row_event_requester dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n_i),
    .event_i    (event_i),
    .req_o      (req_o),
    .gnt_i      (gnt_i),
    .arb_en_o   (arb_en_o),
    .refresh_o  (refresh_o),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_row_o  (evt_row_o),
    .overflow_o (overflow_o)
`ifdef ROWREQ_GNT_CHECK_EN
    ,
    .err_o      (err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int pend [4];
  bit ovf_m, err_m;
  int sent_q [$];
  int n_ref, n_arb, s0, cnt1;

  // round-robin arbiter model: registered grant, pointer restarts at row 0 on refresh
  logic [3:0] gnt_m, force_val;
  bit         force_en, found;
  int         ptr, last_gnt;
  assign gnt_i = force_en ? force_val : gnt_m;

  always @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gnt_m <= '0;
      ptr = 0;
      last_gnt = 0;
    end else if (arb_en_o) begin
      found = 0;
      gnt_m <= '0;
      for (int j = 0; j < 4; j++)
        if (!found && req_o[(ptr + j) % 4]) begin
          found = 1;
          last_gnt = (ptr + j) % 4;
          gnt_m <= 4'(1 << last_gnt);
        end
      if (found) ptr = (last_gnt + 1) % 4;
    end else if (refresh_o) ptr = 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_req();
    for (int r = 0; r < 4; r++) model_req[r] = pend[r] != 0;
  endfunction

  function automatic int exp_row();
    if (!force_en) return last_gnt;
    for (int r = 0; r < 4; r++) if (force_val[r]) return r;
    return 0;
  endfunction

  // one clock: drive at negedge, update the model at posedge, check at the next negedge
  task automatic cyc(input logic [3:0] ev, input logic rdy);
    logic pv;
    logic [1:0] pr;
    int er;
    event_i = ev;
    evt_ready_i = rdy;
    pv = evt_valid_o;
    pr = evt_row_o;
    er = exp_row();
    @(posedge clk);
    if (pv && rdy) begin
      sent_q.push_back(int'(pr));
      chk("hs_pending", 32'(pend[pr] != 0), 1);
      chk("hs_row", 32'(pr), 32'(er));
    end
    for (int r = 0; r < 4; r++) begin
      bit inc, dec;
      inc = ev[r];
      dec = pv && rdy && pr == r;
      if (inc && !dec) begin
        if (pend[r] == 7) ovf_m = 1;
        else pend[r]++;
      end else if (dec && !inc && pend[r] > 0) pend[r]--;
    end
    @(negedge clk);
    chk("req", 32'(req_o), 32'(model_req()));
    chk("overflow", 32'(overflow_o), 32'(ovf_m));
    chk("arb_refresh_excl", 32'(arb_en_o & refresh_o), 0);
`ifdef ROWREQ_GNT_CHECK_EN
    chk("err", 32'(err_o), 32'(err_m));
`endif
    if (pv && !rdy) begin
      chk("stall_valid", 32'(evt_valid_o), 1);
      chk("stall_row", 32'(evt_row_o), 32'(pr));
    end
    if (refresh_o) n_ref++;
    if (arb_en_o) n_arb++;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    #1;
    chk("rst_outputs", 32'({req_o, arb_en_o, refresh_o, evt_valid_o, evt_row_o, overflow_o}), 0);
`ifdef ROWREQ_GNT_CHECK_EN
    chk("rst_err", 32'(err_o), 0);
`endif
    for (int r = 0; r < 4; r++) pend[r] = 0;
    ovf_m = 0;
    err_m = 0;
    event_i = '0;
    @(negedge clk);
    reset_n_i = 1'b1;
  endtask

  task automatic wait_sent(input int n, input int budget);
    for (int c = 0; c < budget && sent_q.size() < n; c++) cyc(4'b0000, 1'b1);
    chk("sent_count", 32'(sent_q.size()), 32'(n));
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 10 && !evt_valid_o; c++) cyc(4'b0000, 1'b0);
    chk("reach_send", 32'(evt_valid_o), 1);
  endtask

  initial begin
    force_en = 0;
    force_val = '0;
    #2;
    do_reset();
    n_ref = 0;
    n_arb = 0;
    cyc(4'b0000, 1'b1);
    chk("first_refresh", 32'(refresh_o), 1);
    cyc(4'b0000, 1'b1);
    chk("refresh_one_cycle", 32'(refresh_o), 0);

    // single event on row 2 with fixed latency
    cyc(4'b0100, 1'b1);
    chk("k0_arb", 32'(arb_en_o), 0);
    cyc(4'b0000, 1'b1);
    chk("k1_arb", 32'(arb_en_o), 1);
    cyc(4'b0000, 1'b1);
    chk("k2_valid", 32'(evt_valid_o), 0);
    cyc(4'b0000, 1'b1);
    chk("k3_valid", 32'(evt_valid_o), 1);
    chk("k3_row", 32'(evt_row_o), 2);
    cyc(4'b0000, 1'b1);
    chk("k4_valid", 32'(evt_valid_o), 0);
    cyc(4'b0000, 1'b1);
    chk("second_refresh", 32'(refresh_o), 1);
    chk("single_arb_count", 32'(n_arb), 1);
    chk("single_refresh_count", 32'(n_ref), 2);

    // multi-hot event, round-robin order 0,1,3 then one refresh
    cyc(4'b0000, 1'b1);
    s0 = sent_q.size();
    n_ref = 0;
    cyc(4'b1011, 1'b1);
    wait_sent(s0 + 3, 40);
    chk("rr_first", 32'(sent_q[s0]), 0);
    chk("rr_second", 32'(sent_q[s0 + 1]), 1);
    chk("rr_third", 32'(sent_q[s0 + 2]), 3);
    repeat (4) cyc(4'b0000, 1'b1);
    chk("rr_refresh_count", 32'(n_ref), 1);

    // backpressure on row 3
    s0 = sent_q.size();
    cyc(4'b1000, 1'b0);
    wait_valid();
    chk("bp_row", 32'(evt_row_o), 3);
    repeat (10) cyc(4'b0000, 1'b0);
    chk("bp_no_send", 32'(sent_q.size()), 32'(s0));
    cyc(4'b0000, 1'b1);
    chk("bp_one_send", 32'(sent_q.size()), 32'(s0 + 1));
    chk("bp_sent_row", 32'(sent_q[s0]), 3);
    repeat (5) cyc(4'b0000, 1'b1);
    chk("bp_no_extra", 32'(sent_q.size()), 32'(s0 + 1));

    // saturation of row 1 while stalled
    s0 = sent_q.size();
    repeat (9) cyc(4'b0010, 1'b0);
    chk("sat_overflow", 32'(overflow_o), 1);
    wait_sent(s0 + 7, 60);
    repeat (8) cyc(4'b0000, 1'b1);
    chk("sat_exact7", 32'(sent_q.size()), 32'(s0 + 7));
    cnt1 = 0;
    for (int i = s0; i < sent_q.size(); i++) if (sent_q[i] == 1) cnt1++;
    chk("sat_all_row1", 32'(cnt1), 7);

    // increment and handshake on row 0 in the same cycle
    cyc(4'b0001, 1'b0);
    wait_valid();
    s0 = sent_q.size();
    cyc(4'b0001, 1'b1);
    chk("simul_req0", 32'(req_o[0]), 1);
    wait_sent(s0 + 2, 20);
    chk("simul_row", 32'(sent_q[s0 + 1]), 0);
    repeat (3) cyc(4'b0000, 1'b1);

    // malformed grant 0110
    s0 = sent_q.size();
    force_val = 4'b0110;
    force_en = 1;
    cyc(4'b0010, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
`ifdef ROWREQ_GNT_CHECK_EN
    err_m = 1;
    cyc(4'b0000, 1'b1);
    chk("gnt_err_no_valid", 32'(evt_valid_o), 0);
    cyc(4'b0000, 1'b1);
    chk("gnt_err_idle_rearb", 32'(arb_en_o), 1);
    chk("gnt_err_no_send", 32'(sent_q.size()), 32'(s0));
    force_en = 0;
    wait_sent(s0 + 1, 20);
`else
    wait_sent(s0 + 1, 20);
    chk("gnt_lowbit_row", 32'(sent_q[s0]), 1);
    force_en = 0;
`endif
    repeat (3) cyc(4'b0000, 1'b1);

    // reset in the middle of SEND
    cyc(4'b0100, 1'b0);
    wait_valid();
    s0 = sent_q.size();
    do_reset();
    cyc(4'b0000, 1'b1);
    chk("refresh_after_rst", 32'(refresh_o), 1);
    repeat (6) cyc(4'b0000, 1'b1);
    chk("rst_discarded", 32'(sent_q.size()), 32'(s0));

    // random traffic against the scoreboard, then drain
    repeat (400) cyc(4'($urandom) & 4'($urandom) & 4'($urandom), $urandom_range(0, 3) != 0);
    for (int c = 0; c < 300 && (model_req() != 0 || evt_valid_o); c++) cyc(4'b0000, 1'b1);
    chk("drain_req", 32'(req_o), 0);
    chk("drain_valid", 32'(evt_valid_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
